// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the MIPS fetch-path PC sequencer: default geometry and FSM state encoding.
// Optional delay-slot behaviour is selected with the BRANCH_DELAY_SLOT_EN macro in pc_sequencer.sv.
package pc_sequencer_pkg;

    localparam int PC_WIDTH      = 32;
    localparam int PC_INCR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    // Only the low two bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// Plain modulo-2^WIDTH adder used to form the sequential next PC (pc + INCR).
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the fetch path: sequential / branch / jump next-PC selection,
// stall handling and misaligned-target trap. Define BRANCH_DELAY_SLOT_EN for one delay slot.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] INCR         = WIDTH'(PC_INCR_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             misalign_err,
    output state_t           state
);

    // Handshake: fetch_valid/pc_out form a request to imem; a transfer happens on a rising edge
    // where fetch_valid & fetch_ready are both 1. stall holds the PC even when a transfer occurs.
    logic [WIDTH-1:0] pc;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;
    logic             advance;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic             accept;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (pc),
        .b   (INCR),
        .sum (pc_plus4)
    );

    assign pc_out          = pc;
    assign advance         = fetch_valid & fetch_ready & ~stall;
    assign redirect        = jump | br_taken;
    assign redirect_target = jump ? jump_target : br_target;

`ifdef BRANCH_DELAY_SLOT_EN
    // slot = delay slot for the pending redirect has not been fetched yet.
    logic slot;
    assign accept = (state == ST_RUN) & redirect & ~pend_valid;
`else
    assign accept = (state == ST_RUN) & redirect;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_VECTOR;
            state        <= ST_BOOT;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
            slot         <= 1'b0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (accept && is_misaligned(redirect_target[1:0])) begin
                        // PC stays on the last aligned address; only reset leaves TRAP.
                        state        <= ST_TRAP;
                        fetch_valid  <= 1'b0;
                        misalign_err <= 1'b1;
                    end else begin
`ifdef BRANCH_DELAY_SLOT_EN
                        if (accept) begin
                            pend_valid  <= 1'b1;
                            pend_target <= redirect_target;
                            slot        <= ~advance;
                            if (advance) pc <= pc_plus4;
                        end else if (advance) begin
                            if (pend_valid && slot) begin
                                pc   <= pc_plus4;
                                slot <= 1'b0;
                            end else if (pend_valid) begin
                                pc         <= pend_target;
                                pend_valid <= 1'b0;
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
`else
                        if (advance) begin
                            if (accept)          pc <= redirect_target;
                            else if (pend_valid) pc <= pend_target;
                            else                 pc <= pc_plus4;
                            pend_valid <= 1'b0;
                        end else if (accept) begin
                            pend_valid  <= 1'b1;
                            pend_target <= redirect_target;
                        end
`endif
                    end
                end
                default: begin
                    state       <= ST_TRAP;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        misalign_err;
    state_t      state;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .fetch_ready  (fetch_ready),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .misalign_err (misalign_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Reference model: fetch phase, current PC and a one-deep redirect queue.
    bit          m_booting;
    bit          m_running;
    bit          m_trapped;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_slot_due;

    task automatic model_reset();
        m_booting  = 1'b1;
        m_running  = 1'b0;
        m_trapped  = 1'b0;
        m_pc       = 32'h0;
        m_pend.delete();
        m_slot_due = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit fr, input bit br, input logic [31:0] bt,
                              input bit j, input logic [31:0] jt);
        bit          adv;
        bit          req;
        logic [31:0] tgt;
        if (m_booting) begin
            m_booting = 1'b0;
            m_running = 1'b1;
            return;
        end
        if (!m_running) return;
        adv = fr && !st;
        req = br || j;
        tgt = j ? jt : bt;
`ifdef BRANCH_DELAY_SLOT_EN
        if (m_pend.size() != 0) req = 1'b0;
`endif
        if (req && (tgt % 4) != 0) begin
            m_running = 1'b0;
            m_trapped = 1'b1;
            return;
        end
        if (req) begin
            m_pend.delete();
            m_pend.push_back(tgt);
            m_slot_due = 1'b1;
        end
        if (adv) begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (m_pend.size() != 0 && !m_slot_due) m_pc = m_pend.pop_front();
            else m_pc = m_pc + 32'd4;
            m_slot_due = 1'b0;
`else
            if (m_pend.size() != 0) m_pc = m_pend.pop_front();
            else m_pc = m_pc + 32'd4;
`endif
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_out"}, pc_out, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, m_running});
        check({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_trapped});
    endtask

    task automatic cycle(input string tag, input bit st, input bit fr, input bit br,
                         input logic [31:0] bt, input bit j, input logic [31:0] jt);
        stall       = st;
        fetch_ready = fr;
        br_taken    = br;
        br_target   = bt;
        jump        = j;
        jump_target = jt;
        model_edge(st, fr, br, bt, j, jt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        check("reset_pc_const", pc_out, 32'h0);
        rst_n = 1'b1;

        cycle("boot", 0, 1, 0, 0, 0, 0);
        check("boot_fv_const", {31'b0, fetch_valid}, 32'd1);
        cycle("seq1", 0, 1, 0, 0, 0, 0);
        cycle("seq2", 0, 1, 0, 0, 0, 0);
        check("seq_pc8", pc_out, 32'h8);
        check("seq_plus4_c", pc_plus4, 32'hC);
        for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("not_ready", 0, 0, 0, 0, 0, 0);
        check("hold_pc8", pc_out, 32'h8);

        cycle("jump_vs_br", 0, 1, 1, 32'h200, 1, 32'h100);
`ifdef BRANCH_DELAY_SLOT_EN
        check("slot_pc", pc_out, 32'hC);
        cycle("slot_target", 0, 1, 0, 0, 0, 0);
`endif
        check("jump_pc", pc_out, 32'h100);

        cycle("stall_redirect", 1, 1, 0, 0, 1, 32'h40);
        cycle("stall_hold", 1, 1, 0, 0, 0, 0);
        cycle("stall_release", 0, 1, 0, 0, 0, 0);
`ifdef BRANCH_DELAY_SLOT_EN
        cycle("stall_slot", 0, 1, 0, 0, 0, 0);
`endif
        check("pending_pc", pc_out, 32'h40);

        cycle("to_top", 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
`ifdef BRANCH_DELAY_SLOT_EN
        cycle("to_top_slot", 0, 1, 0, 0, 0, 0);
`endif
        check("top_pc", pc_out, 32'hFFFF_FFFC);
        check("top_plus4_wrap", pc_plus4, 32'h0);
        cycle("wrap", 0, 1, 0, 0, 0, 0);
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_no_err", {31'b0, misalign_err}, 32'd0);

        cycle("seq3", 0, 1, 0, 0, 0, 0);
        cycle("misalign", 0, 1, 1, 32'h102, 0, 0);
        check("trap_err", {31'b0, misalign_err}, 32'd1);
        check("trap_fv", {31'b0, fetch_valid}, 32'd0);
        check("trap_pc", pc_out, 32'h4);
        cycle("trap_jump", 0, 1, 0, 0, 1, 32'h300);
        cycle("trap_stall", 1, 1, 1, 32'h500, 0, 0);
        check("trap_held", pc_out, 32'h4);
        apply_reset("trap_reset");
        check("trap_cleared", {31'b0, misalign_err}, 32'd0);

        begin
            int trap_cycles = 0;
            for (int i = 0; i < 500; i++) begin
                bit          st;
                bit          fr;
                bit          br;
                bit          j;
                logic [31:0] bt;
                logic [31:0] jt;
                st = ($urandom_range(0, 3) == 0);
                fr = ($urandom_range(0, 3) != 0);
                br = ($urandom_range(0, 5) == 0);
                j  = ($urandom_range(0, 7) == 0);
                bt = $urandom() & 32'hFFFF_FFFC;
                jt = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 40) == 0) bt[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 40) == 0) jt[1:0] = 2'($urandom_range(1, 3));
                cycle("rand", st, fr, br, bt, j, jt);
                if (m_trapped) trap_cycles++;
                if (trap_cycles > 3 || $urandom_range(0, 99) == 0) begin
                    trap_cycles = 0;
                    apply_reset("rand_reset");
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
